// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
// Covers a 4-input function: 16 vectors, 5-bit match count.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_EMIT,
    S_FINISH
  } state_e;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;
  localparam int CNT_W       = 5;

endpackage

// File: rtl/truth_table_emitter.sv
// Walks the captured table and emits the indices whose bit matches
// MATCH_VAL, one per accepted valid/ready handshake, in ascending order.
module truth_table_emitter
  import truth_table_scanner_pkg::*;
#(
  parameter bit MATCH_VAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [NUM_VECTORS-1:0] table_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [VEC_W-1:0]       data_o,
  output logic                   last_o
);

  logic [VEC_W-1:0] ptr_q, ptr_d;
  logic             hit;
  logic             adv;

  assign hit     = (table_i[ptr_q] == MATCH_VAL);
  assign valid_o = en_i && hit;
  // Non-matching bits are skipped in one cycle; matches wait for ready.
  assign adv     = en_i && (!hit || ready_i);
  assign last_o  = adv && (ptr_q == VEC_W'(NUM_VECTORS - 1));
  assign data_o  = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (!en_i) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = ptr_q + VEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps 16 vectors into a 4-input function block, captures F into a
// truth table and streams out the matching minterm/maxterm indices.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          MATCH_VAL     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  input  logic        f_in,
  output logic        busy,
  output logic [15:0] table_out,
  output logic [4:0]  match_cnt,
  output logic        idx_valid,
  input  logic        idx_ready,
  output logic [3:0]  idx_data,
  output logic        done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VLAST = VEC_W'(NUM_VECTORS - 1);

  state_e                 state_q, state_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic [SW-1:0]          set_q, set_d;
  logic [NUM_VECTORS-1:0] tab_q, tab_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   emit_last;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    set_d   = set_q;
    tab_d   = tab_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          vec_d   = '0;
          set_d   = '0;
          tab_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (set_q == SLAST) begin
          set_d        = '0;
          tab_d[vec_q] = f_in;
          if (f_in == MATCH_VAL) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Vector stays at 15 once the sweep is over.
          if (vec_q == VLAST) begin
            state_d = S_EMIT;
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end else begin
          set_d = set_q + SW'(1);
        end
      end
      S_EMIT: begin
        if (emit_last) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      set_q   <= '0;
      tab_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
      tab_q   <= tab_d;
      cnt_q   <= cnt_d;
    end
  end

  truth_table_emitter #(
    .MATCH_VAL (MATCH_VAL)
  ) u_emit (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == S_EMIT),
    .table_i (tab_q),
    .ready_i (idx_ready),
    .valid_o (idx_valid),
    .data_o  (idx_data),
    .last_o  (emit_last)
  );

  assign {a_out, b_out, c_out, d_out} = vec_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign table_out = tab_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances cover both polarities
// and a 3-cycle settle time against a behavioural function model.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       start_v = '0;
  logic [2:0]       ready_v = '1;
  logic [2:0]       f_v;
  logic [2:0]       a_v, b_v, c_v, d_v;
  logic [2:0]       busy_v, done_v, valid_v;
  logic [2:0][15:0] tab_v;
  logic [2:0][4:0]  cnt_v;
  logic [2:0][3:0]  data_v;
  int               fmode [3] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;

  // mode 0: reference POS function, 1: tied 0, 2: tied 1
  function automatic logic fmodel(input int mode, input logic [3:0] v);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return !(v inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd12, 4'd14});
  endfunction

  assign f_v[0] = fmodel(fmode[0], {a_v[0], b_v[0], c_v[0], d_v[0]});
  assign f_v[1] = fmodel(fmode[1], {a_v[1], b_v[1], c_v[1], d_v[1]});
  assign f_v[2] = fmodel(fmode[2], {a_v[2], b_v[2], c_v[2], d_v[2]});

  truth_table_scanner #(.SETTLE_CYCLES(1), .MATCH_VAL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .c_out(c_v[0]), .d_out(d_v[0]),
    .f_in(f_v[0]), .busy(busy_v[0]), .table_out(tab_v[0]),
    .match_cnt(cnt_v[0]), .idx_valid(valid_v[0]),
    .idx_ready(ready_v[0]), .idx_data(data_v[0]), .done(done_v[0]));

  truth_table_scanner #(.SETTLE_CYCLES(1), .MATCH_VAL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .c_out(c_v[1]), .d_out(d_v[1]),
    .f_in(f_v[1]), .busy(busy_v[1]), .table_out(tab_v[1]),
    .match_cnt(cnt_v[1]), .idx_valid(valid_v[1]),
    .idx_ready(ready_v[1]), .idx_data(data_v[1]), .done(done_v[1]));

  truth_table_scanner #(.SETTLE_CYCLES(3), .MATCH_VAL(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a_out(a_v[2]), .b_out(b_v[2]), .c_out(c_v[2]), .d_out(d_v[2]),
    .f_in(f_v[2]), .busy(busy_v[2]), .table_out(tab_v[2]),
    .match_cnt(cnt_v[2]), .idx_valid(valid_v[2]),
    .idx_ready(ready_v[2]), .idx_data(data_v[2]), .done(done_v[2]));

  function automatic logic [3:0] vecof(input int i);
    return {a_v[i], b_v[i], c_v[i], d_v[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int i, input string tag);
    check({tag, " busy"}, 32'(busy_v[i]), 0);
    check({tag, " done"}, 32'(done_v[i]), 0);
    check({tag, " valid"}, 32'(valid_v[i]), 0);
    check({tag, " table"}, 32'(tab_v[i]), 0);
    check({tag, " cnt"}, 32'(cnt_v[i]), 0);
    check({tag, " vec"}, 32'(vecof(i)), 0);
    check({tag, " data"}, 32'(data_v[i]), 0);
  endtask

  // extra: 1 = re-pulse start mid-sweep and track vectors, 2 = start at done
  task automatic run_scan(input int inst, input int mode, input bit mv,
                          input int rmode, input int extra,
                          input logic [15:0] et, input int ec,
                          input int ecyc, input int settle);
    int  q[$];
    int  cyc;
    int  exp_idx;
    int  stall_left;
    bit  stalled;
    bit  seen_done;
    bit  busy_bad;
    bit  vec_bad;
    fmode[inst] = mode;
    for (int i = 0; i < 16; i++)
      if (fmodel(mode, 4'(i)) == mv) q.push_back(i);
    stall_left = 0;
    stalled = 0;
    seen_done = 0;
    busy_bad = 0;
    vec_bad = 0;
    @(negedge clk);
    check($sformatf("idle busy i%0d", inst), 32'(busy_v[inst]), 0);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    cyc = 1;
    while (!seen_done && cyc < 1000) begin
      if (done_v[inst]) begin
        seen_done = 1'b1;
      end else begin
        if (!busy_v[inst]) busy_bad = 1'b1;
        if (extra == 1) begin
          start_v[inst] = (cyc == 10);
          if (cyc <= 16 * settle && vecof(inst) != 4'((cyc - 1) / settle))
            vec_bad = 1'b1;
        end
        if (stall_left > 0) begin
          ready_v[inst] = 1'b0;
          check("stall hold", {30'd0, valid_v[inst], data_v[inst] == 4'd6},
                32'd3);
          stall_left--;
        end else if (rmode == 1 && !stalled && valid_v[inst] &&
                     data_v[inst] == 4'd6) begin
          stalled = 1'b1;
          ready_v[inst] = 1'b0;
          stall_left = 9;
          check("stall hold", {30'd0, valid_v[inst], data_v[inst] == 4'd6},
                32'd3);
        end else begin
          ready_v[inst] = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        if (valid_v[inst] && ready_v[inst]) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra index: got %0d expected none",
                     data_v[inst]);
          end else begin
            exp_idx = q.pop_front();
            check("index", 32'(data_v[inst]), 32'(exp_idx));
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start_v[inst] = 1'b0;
    ready_v[inst] = 1'b1;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done i%0d", inst);
      return;
    end
    if (ecyc != 0) check("done latency", 32'(cyc), 32'(ecyc));
    check("table", 32'(tab_v[inst]), 32'(et));
    check("match_cnt", 32'(cnt_v[inst]), 32'(ec));
    check("missing idx", 32'(q.size()), 0);
    check("busy during run", 32'(busy_bad), 0);
    if (extra == 1) check("vector sweep", 32'(vec_bad), 0);
    if (extra == 2) start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    check("done one pulse", 32'(done_v[inst]), 0);
    check("busy after", 32'(busy_v[inst]), 0);
    check("vec hold", 32'(vecof(inst)), 32'd15);
    if (extra == 2) begin
      @(negedge clk);
      check("start at done ignored", 32'(busy_v[inst]), 0);
    end
  endtask

  typedef struct {
    int          inst;
    int          mode;
    bit          mv;
    int          rmode;
    int          extra;
    logic [15:0] et;
    int          ec;
    int          ecyc;
    int          settle;
  } vec_t;

  vec_t tv[7];

  initial begin
    int n;
    tv[0] = '{0, 0, 1'b1, 0, 2, 16'hAAF8, 9, 33, 1};
    tv[1] = '{1, 0, 1'b0, 0, 0, 16'hAAF8, 7, 33, 1};
    tv[2] = '{0, 1, 1'b1, 0, 0, 16'h0000, 0, 33, 1};
    tv[3] = '{0, 2, 1'b1, 0, 0, 16'hFFFF, 16, 33, 1};
    tv[4] = '{1, 1, 1'b0, 0, 0, 16'h0000, 16, 33, 1};
    tv[5] = '{2, 0, 1'b1, 0, 1, 16'hAAF8, 9, 65, 3};
    tv[6] = '{0, 0, 1'b1, 1, 0, 16'hAAF8, 9, 0, 1};

    #12;
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++)
      run_scan(tv[k].inst, tv[k].mode, tv[k].mv, tv[k].rmode, tv[k].extra,
               tv[k].et, tv[k].ec, tv[k].ecyc, tv[k].settle);

    // Abort during EMIT after four accepted indices.
    fmode[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      if (valid_v[0] && ready_v[0]) n++;
      @(negedge clk);
    end
    check("reset point accepted", 32'(n), 32'd4);
    check("reset point busy", 32'(busy_v[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0, "async reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no done in reset", 32'(done_v[0]), 0);
    end
    rst_n = 1'b1;
    run_scan(0, 0, 1'b1, 0, 0, 16'hAAF8, 9, 33, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential reader for the team's 4-input combinational logic-function blocks (single output F of inputs A,B,C,D).
- Sweeps all 16 input vectors onto the function under test and samples F into a 16-bit truth table.
- Then streams out, over a valid/ready handshake, the index of every vector whose F equals a selected polarity (minterm or maxterm list).
- Used as on-chip self-check and table extractor for the function blocks.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before F is sampled (>=1).
- MATCH_VAL, 1, F value whose indices are emitted: 1 = minterm list, 0 = maxterm list.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; ignored unless busy=0.
- a_out, b_out, c_out, d_out  out  1 each  vector driven to function under test; index i = {A,B,C,D}, A is MSB.
- f_in  in  1  combinational F returned by function under test.
- busy  out  1  high from the cycle after an accepted start until done.
- table_out  out  16  captured truth table; bit i = F(i); valid when busy=0.
- match_cnt  out  5  number of table bits equal to MATCH_VAL (0..16).
- idx_valid  out  1  emitted index valid.
- idx_ready  in  1  downstream accepts index.
- idx_data  out  4  emitted vector index.
- done  out  1  one-cycle pulse when emission completes.

Behaviour:
- Reset (async, rst_n=0), all outputs 0: state=IDLE, vector=0, table_out=0, match_cnt=0, idx_valid=0, busy=0, done=0. Reset mid-sweep or mid-emit aborts immediately; no partial done.
- States: IDLE, SWEEP, EMIT, FINISH.
- IDLE:
  - start=1 -> SWEEP.
  - vector counter=0, settle counter=0, table_out and match_cnt cleared on that edge.
- SWEEP:
  - {a,b,c,d}_out = vector counter.
  - Each vector is held exactly SETTLE_CYCLES cycles. On the edge ending the hold, table_out[vector] <= f_in; match_cnt increments if f_in==MATCH_VAL.
  - Vector increments 0..15. After sampling vector 15 -> EMIT with scan pointer=0.
  - Sweep length = 16*SETTLE_CYCLES cycles.
- EMIT:
  - Scan pointer p walks 0..15, one bit per cycle.
  - If table_out[p]!=MATCH_VAL, p increments with no output.
  - If it matches, idx_valid=1 and idx_data=p, held stable until idx_valid&&idx_ready. On the accepting edge p increments.
  - Pointer at 15 after its bit is skipped or accepted -> FINISH. No index is emitted twice; indices are emitted in ascending order.
  - idx_ready is irrelevant while idx_valid=0. Back-pressure may stall indefinitely.
- FINISH: done=1 for one cycle, busy=0 on the next edge -> IDLE. table_out and match_cnt hold until the next start.
- Vector outputs hold their last value (15) after SWEEP.
- start while busy is ignored, with no restart.
- start asserted in the same cycle as the done pulse is ignored; it is accepted only from IDLE.
- Zero matches: no idx_valid ever; done occurs 16 cycles after EMIT entry.
- 16 matches: match_cnt=16 (5 bits, no wrap).
- SETTLE_CYCLES=1 is the minimum; f_in is sampled in the same cycle the vector is driven, so the function under test must be purely combinational.

Decomposition:
- Shared package holds:
  - state enum (IDLE/SWEEP/EMIT/FINISH);
  - constants NUM_VECTORS=16, VEC_W=4, CNT_W=5.
- One natural sub-module: truth_table_emitter (EMIT scan pointer plus valid/ready hold logic), fed by table_out and MATCH_VAL. Sweep/capture stays in the top module.

Test Plan:
1. Connect the team's reference POS function (maxterms 0,1,2,8,10,12,14), MATCH_VAL=1, idx_ready=1, SETTLE_CYCLES=1, pulse start -> table_out=0xAAF8, match_cnt=9, indices 3,4,5,6,7,9,11,13,15 in order, one done pulse, busy low after.
2. Same function, MATCH_VAL=0 -> match_cnt=7, indices 0,1,2,8,10,12,14.
3. Test 1 with idx_ready toggling randomly and held low 10 cycles at index 6 -> idx_data stays 6 with idx_valid=1 throughout the stall, no index lost or duplicated.
4. f_in tied 0, MATCH_VAL=1 -> table_out=0x0000, match_cnt=0, no idx_valid, done exactly 16+16+1 cycles after start; f_in tied 1 -> 0xFFFF, match_cnt=16, indices 0..15.
5. SETTLE_CYCLES=3 -> each vector held 3 cycles, sweep lasts 48 cycles, same table as test 1; start re-pulsed mid-sweep ignored.
6. rst_n low during EMIT after 4 indices -> all outputs 0 asynchronously, no done. A new start after reset runs a full clean scan.
